// File: rtl/pipe_chain_pkg.sv
// Shared defaults and helpers for the pipe_stage_chain slice.
// The PIPE_CHAIN_STATS_EN build macro is consumed by pipe_stage_chain.
package pipe_chain_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 16;
    // Upper bound on DEPTH; stall vectors are zero-padded to this width for or_suffix.
    localparam int MAX_DEPTH     = 64;

    function automatic int stage_slice(input int k, input int width);
        return k * width;
    endfunction

    // A stall at any stage at or after k freezes stage k.
    function automatic logic or_suffix(input logic [MAX_DEPTH-1:0] stall, input int k);
        return |(stall >> k);
    endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// Upstream/downstream stream signals of the pipeline chain.
// The chain itself uses the slave modport.
interface pipe_chain_if
    import pipe_chain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline register: valid + payload with hold/flush/load selection.
// With ZERO_BUBBLE set, loading a bubble clears the payload.
module pipe_stage_reg
    import pipe_chain_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hold,
    input  logic             flush,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (hold) begin
            // A held item can still be killed; its payload stays put.
            valid_reg <= valid_reg & ~flush;
        end else begin
            valid_reg <= src_valid;
            data_reg  <= (ZERO_BUBBLE != 0 && !src_valid) ? '0 : src_data;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage pipeline register chain with per-stage stall (propagating upstream),
// bubble insertion and flush. Define PIPE_CHAIN_STATS_EN for bubble/flush counters.
module pipe_stage_chain
    import pipe_chain_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    pipe_chain_if.slave            bus,
    input  logic [DEPTH-1:0]       stall_i,
    input  logic [DEPTH-1:0]       flush_i,
    output logic [DEPTH-1:0]       stage_valid_o,
    output logic [DEPTH*WIDTH-1:0] stage_data_o,
    output logic [CNT_W-1:0]       bubble_cnt_o,
    output logic [CNT_W-1:0]       flush_cnt_o
);

    logic [MAX_DEPTH-1:0] stall_pad;
    logic [DEPTH-1:0]     hold;
    logic [DEPTH-1:0]     src_valid;
    logic [DEPTH-1:0]     valid;
    logic [WIDTH-1:0]     src_data [DEPTH];
    logic [WIDTH-1:0]     data     [DEPTH];

    assign stall_pad = MAX_DEPTH'(stall_i);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            assign hold[gi] = or_suffix(stall_pad, gi);

            if (gi == 0) begin : g_head
                assign src_valid[gi] = bus.in_valid;
                assign src_data[gi]  = bus.in_data;
            end else begin : g_link
                // A held or flushed predecessor hands down a bubble.
                assign src_valid[gi] = valid[gi-1] & ~flush_i[gi-1] & ~hold[gi-1];
                assign src_data[gi]  = data[gi-1];
            end

            pipe_stage_reg #(
                .WIDTH       (WIDTH),
                .ZERO_BUBBLE (ZERO_BUBBLE)
            ) u_stage (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .hold      (hold[gi]),
                .flush     (flush_i[gi]),
                .src_valid (src_valid[gi]),
                .src_data  (src_data[gi]),
                .valid     (valid[gi]),
                .data      (data[gi])
            );

            assign stage_data_o[stage_slice(gi, WIDTH) +: WIDTH] = data[gi];
        end
    endgenerate

    assign stage_valid_o = valid;
    assign bus.in_ready  = ~hold[0];
    assign bus.out_valid = valid[DEPTH-1];
    assign bus.out_data  = data[DEPTH-1];

`ifdef PIPE_CHAIN_STATS_EN
    logic [CNT_W-1:0] bubble_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bubble_cnt_reg <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            if (!valid[DEPTH-1] && bubble_cnt_reg != '1)
                bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
            if (|(valid & flush_i) && flush_cnt_reg != '1)
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign bubble_cnt_o = bubble_cnt_reg;
    assign flush_cnt_o  = flush_cnt_reg;
`else
    assign bubble_cnt_o = '0;
    assign flush_cnt_o  = '0;
`endif

endmodule
